fwd_producer_pipe: RTL and testbench

//  Producer side of the ID-stage branch-operand forwarding bus. Holds the EX/MEM and MEM/WB

---
 rtl/fwd_producer_pipe.sv | 77 +++++++
 tb/tb_fwd_producer_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_producer_pipe.sv
// EX/MEM and MEM/WB pipeline registers that feed the ID-stage branch forwarding bus,
// plus the stall request for branch operands the forwarding paths cannot yet supply.
module fwd_producer_pipe #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] ALUResultE,
    input  logic [DW-1:0] PC8E,
    input  logic          LinkE,
    input  logic [AW-1:0] RdE,
    input  logic          RegWriteE,
    input  logic          MemtoRegE,
    input  logic          FlushE,
    input  logic [DW-1:0] MemRDataM,
    input  logic          BranchD,
    input  logic          UsesRtD,
    input  logic [AW-1:0] RsD,
    input  logic [AW-1:0] RtD,
    output logic [AW-1:0] RdM,
    output logic [DW-1:0] ALUResultM,
    output logic          RegWriteM,
    output logic          MemtoRegM,
    output logic [AW-1:0] RdW,
    output logic [DW-1:0] WData,
    output logic          RegWriteW,
    output logic          BranchStallD
);

    logic writesE;
    logic rsLive;
    logic rtLive;
    logic hitE;
    logic hitM;

    // A write to $0 is dropped here so nothing downstream ever forwards from it.
    assign writesE = RegWriteE && (RdE != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            RdM        <= '0;
            ALUResultM <= '0;
            RegWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            RdW        <= '0;
            WData      <= '0;
            RegWriteW  <= 1'b0;
        end else begin
            if (FlushE) begin
                RdM        <= '0;
                ALUResultM <= '0;
                RegWriteM  <= 1'b0;
                MemtoRegM  <= 1'b0;
            end else begin
                RdM        <= RdE;
                ALUResultM <= LinkE ? PC8E : ALUResultE;
                RegWriteM  <= writesE;
                MemtoRegM  <= MemtoRegE && writesE;
            end
            RdW       <= RdM;
            RegWriteW <= RegWriteM;
            WData     <= MemtoRegM ? MemRDataM : ALUResultM;
        end
    end

    // Only MEM non-load results and WB data are forwardable; EX results and MEM loads are not.
    always_comb begin
        rsLive       = (RsD != '0);
        rtLive       = UsesRtD && (RtD != '0);
        hitE         = RegWriteE && ((rsLive && (RdE == RsD)) || (rtLive && (RdE == RtD)));
        hitM         = RegWriteM && MemtoRegM &&
                       ((rsLive && (RdM == RsD)) || (rtLive && (RdM == RtD)));
        BranchStallD = BranchD && (hitE || hitM);
    end

endmodule

// File: tb/tb_fwd_producer_pipe.sv
// Directed vector table, hand-written stall sequences and a randomized run against a
// cycle-history reference model for fwd_producer_pipe.
module tb_fwd_producer_pipe;

    localparam int NRAND = 300;

    typedef struct {
        logic        reset;
        logic        flush;
        logic [4:0]  rdE;
        logic [31:0] resE;
        logic [31:0] pc8;
        logic        link;
        logic        rwE;
        logic        ldE;
        logic [31:0] memData;
        logic        branch;
        logic        usesRt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [1:0]  chk;
        logic [4:0]  xRdM;
        logic [31:0] xResM;
        logic        xRwM;
        logic        xLdM;
        logic [4:0]  xRdW;
        logic [31:0] xWData;
        logic        xRwW;
        logic        xStall;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rw;
        logic        ld;
    } stage_t;

    logic        clk;
    logic        reset;
    logic [31:0] ALUResultE;
    logic [31:0] PC8E;
    logic        LinkE;
    logic [4:0]  RdE;
    logic        RegWriteE;
    logic        MemtoRegE;
    logic        FlushE;
    logic [31:0] MemRDataM;
    logic        BranchD;
    logic        UsesRtD;
    logic [4:0]  RsD;
    logic [4:0]  RtD;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM;
    logic        RegWriteM;
    logic        MemtoRegM;
    logic [4:0]  RdW;
    logic [31:0] WData;
    logic        RegWriteW;
    logic        BranchStallD;

    int assertCount = 0;
    int failCount   = 0;

    vec_t tbl[14];
    vec_t hist[NRAND];

    fwd_producer_pipe #(.DW(32), .AW(5)) dut (
        .clk(clk), .reset(reset), .ALUResultE(ALUResultE), .PC8E(PC8E), .LinkE(LinkE),
        .RdE(RdE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .FlushE(FlushE),
        .MemRDataM(MemRDataM), .BranchD(BranchD), .UsesRtD(UsesRtD), .RsD(RsD), .RtD(RtD),
        .RdM(RdM), .ALUResultM(ALUResultM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .RdW(RdW), .WData(WData), .RegWriteW(RegWriteW), .BranchStallD(BranchStallD)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t idle();
        vec_t v;
        v = '{1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0,
              2'd0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0};
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        reset      = v.reset;
        FlushE     = v.flush;
        RdE        = v.rdE;
        ALUResultE = v.resE;
        PC8E       = v.pc8;
        LinkE      = v.link;
        RegWriteE  = v.rwE;
        MemtoRegE  = v.ldE;
        MemRDataM  = v.memData;
        BranchD    = v.branch;
        UsesRtD    = v.usesRt;
        RsD        = v.rs;
        RtD        = v.rt;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input vec_t v);
        checkOutput({tag, " RdM"}, 32'(RdM), 32'(v.xRdM));
        checkOutput({tag, " ALUResultM"}, ALUResultM, v.xResM);
        checkOutput({tag, " RegWriteM"}, 32'(RegWriteM), 32'(v.xRwM));
        checkOutput({tag, " MemtoRegM"}, 32'(MemtoRegM), 32'(v.xLdM));
        checkOutput({tag, " RdW"}, 32'(RdW), 32'(v.xRdW));
        checkOutput({tag, " WData"}, WData, v.xWData);
        checkOutput({tag, " RegWriteW"}, 32'(RegWriteW), 32'(v.xRwW));
        checkOutput({tag, " BranchStallD"}, 32'(BranchStallD), 32'(v.xStall));
    endtask

    // One cycle: drive just after the edge, sample a little later, well before the next edge.
    task automatic runCycle(input string tag, input vec_t v);
        @(posedge clk);
        #1 applyStimulus(v);
        #2;
        if (v.chk == 2'd1) checkAll(tag, v);
        else if (v.chk == 2'd2) checkOutput({tag, " BranchStallD"}, 32'(BranchStallD), 32'(v.xStall));
    endtask

    // What the MEM stage holds after the edge that ends cycle c of the random run.
    function automatic stage_t memAfter(int c);
        stage_t s;
        s = '{5'd0, 32'd0, 1'b0, 1'b0};
        if (c < 0) return s;
        if (hist[c].reset || hist[c].flush) return s;
        s.rd   = hist[c].rdE;
        s.data = hist[c].link ? hist[c].pc8 : hist[c].resE;
        s.rw   = hist[c].rwE && (hist[c].rdE != 5'd0);
        s.ld   = hist[c].ldE && s.rw;
        return s;
    endfunction

    function automatic stage_t wbAfter(int c);
        stage_t s;
        stage_t m;
        s = '{5'd0, 32'd0, 1'b0, 1'b0};
        if (c < 1 || hist[c].reset) return s;
        m      = memAfter(c - 1);
        s.rd   = m.rd;
        s.rw   = m.rw;
        s.data = m.ld ? hist[c].memData : m.data;
        return s;
    endfunction

    function automatic logic srcBlocked(logic [4:0] src, vec_t v, stage_t m);
        if (src == 5'd0) return 1'b0;
        return (v.rwE && v.rdE == src) || (m.rw && m.ld && m.rd == src);
    endfunction

    initial begin
        vec_t   v;
        stage_t m;
        stage_t w;

        applyStimulus(idle());

        tbl[0]  = '{1'b1, 1'b1, 5'd7, 32'h55, 32'h99, 1'b1, 1'b1, 1'b1, 32'hAB, 1'b0, 1'b1, 5'd7, 5'd7,
                    2'd0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 5'd7, 32'h55, 32'h99, 1'b1, 1'b1, 1'b1, 32'hAB, 1'b0, 1'b1, 5'd7, 5'd7,
                    2'd1, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 5'd5, 32'h1234, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0,
                    2'd1, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0,
                    2'd1, 5'd5, 32'h1234, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 5'd8, 32'h100, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0,
                    2'd1, 5'd0, 32'h0, 1'b0, 1'b0, 5'd5, 32'h1234, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 5'd0,
                    2'd1, 5'd8, 32'h100, 1'b1, 1'b1, 5'd0, 32'h0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0,
                    2'd1, 5'd0, 32'h0, 1'b0, 1'b0, 5'd8, 32'hDEADBEEF, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 5'd0, 32'h77, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 5'd0, 5'd0,
                    2'd1, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0,
                    2'd1, 5'd0, 32'h77, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 5'd31, 32'hAAAA, 32'h3008, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 5'd2, 5'd31,
                    2'd1, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h77, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0,
                    2'd1, 5'd31, 32'h3008, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 5'd31, 32'hAAAA, 32'h3008, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 5'd31, 5'd0,
                    2'd1, 5'd0, 32'h0, 1'b0, 1'b0, 5'd31, 32'h3008, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0,
                    2'd1, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0,
                    2'd1, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0};

        for (int i = 0; i < 14; i++) runCycle($sformatf("vec%0d", i), tbl[i]);

        // Load r3 in EX with beq on r3: stalled while load is in EX, then while it is in MEM.
        v = idle(); v.reset = 1'b1; runCycle("ldReset", v);
        v = idle(); v.rdE = 5'd3; v.rwE = 1'b1; v.ldE = 1'b1; v.resE = 32'h40;
        v.branch = 1'b1; v.usesRt = 1'b1; v.rs = 5'd3; v.rt = 5'd9; v.chk = 2'd2; v.xStall = 1'b1;
        runCycle("ldStall1", v);
        v = idle(); v.flush = 1'b1; v.branch = 1'b1; v.usesRt = 1'b1; v.rs = 5'd3; v.rt = 5'd9;
        v.chk = 2'd2; v.xStall = 1'b1;
        runCycle("ldStall2", v);
        v = idle(); v.branch = 1'b1; v.usesRt = 1'b1; v.rs = 5'd3; v.rt = 5'd9;
        v.chk = 2'd2; v.xStall = 1'b0;
        runCycle("ldStall3", v);

        // ALU producer on Rt: one stall cycle, then the MEM-stage value is forwardable.
        v = idle(); v.rdE = 5'd4; v.rwE = 1'b1; v.branch = 1'b1; v.usesRt = 1'b1; v.rs = 5'd1;
        v.rt = 5'd4; v.chk = 2'd2; v.xStall = 1'b1;
        runCycle("aluStall1", v);
        v = idle(); v.flush = 1'b1; v.branch = 1'b1; v.usesRt = 1'b1; v.rs = 5'd1; v.rt = 5'd4;
        v.chk = 2'd2; v.xStall = 1'b0;
        runCycle("aluStall2", v);

        // Load on Rs in MEM and ALU on Rt in EX at once.
        v = idle(); v.rdE = 5'd6; v.rwE = 1'b1; v.ldE = 1'b1; runCycle("bothPrep", v);
        v = idle(); v.rdE = 5'd7; v.rwE = 1'b1; v.branch = 1'b1; v.usesRt = 1'b1; v.rs = 5'd6;
        v.rt = 5'd7; v.chk = 2'd2; v.xStall = 1'b1;
        runCycle("bothStall", v);
        v = idle(); v.flush = 1'b1; v.branch = 1'b1; v.usesRt = 1'b1; v.rs = 5'd6; v.rt = 5'd7;
        v.chk = 2'd2; v.xStall = 1'b0;
        runCycle("bothClear", v);

        // Reset while a load-use stall is pending empties the pipe.
        v = idle(); v.reset = 1'b1; v.rdE = 5'd3; v.rwE = 1'b1; v.ldE = 1'b1;
        v.branch = 1'b1; v.rs = 5'd3; v.chk = 2'd2; v.xStall = 1'b1;
        runCycle("rstStall", v);
        v = idle(); v.branch = 1'b1; v.rs = 5'd3; v.chk = 2'd2; v.xStall = 1'b0;
        runCycle("rstClear", v);

        for (int c = 0; c < NRAND; c++) begin
            v         = idle();
            v.reset   = (c == 0) || ($urandom_range(0, 39) == 0);
            v.flush   = ($urandom_range(0, 4) == 0);
            v.rdE     = 5'($urandom_range(0, 7));
            v.resE    = $urandom;
            v.pc8     = $urandom;
            v.link    = ($urandom_range(0, 3) == 0);
            v.rwE     = ($urandom_range(0, 3) != 0);
            v.ldE     = ($urandom_range(0, 2) == 0);
            v.memData = $urandom;
            v.branch  = 1'($urandom_range(0, 1));
            v.usesRt  = 1'($urandom_range(0, 1));
            v.rs      = 5'($urandom_range(0, 7));
            v.rt      = 5'($urandom_range(0, 7));
            hist[c]   = v;
            if (c > 0) begin
                m        = memAfter(c - 1);
                w        = wbAfter(c - 1);
                v.chk    = 2'd1;
                v.xRdM   = m.rd;
                v.xResM  = m.data;
                v.xRwM   = m.rw;
                v.xLdM   = m.ld;
                v.xRdW   = w.rd;
                v.xWData = w.data;
                v.xRwW   = w.rw;
                v.xStall = v.branch && (srcBlocked(v.rs, v, m) ||
                                        (v.usesRt && srcBlocked(v.rt, v, m)));
            end
            runCycle($sformatf("rnd%0d", c), v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
